// File: rtl/matmul_sequencer_if.sv
// Operand/result/status bundle between the MAC sequencer and its datapath.
interface matmul_sequencer_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              rd_en;
  logic              acc_en;
  logic              acc_first;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic              busy;
  logic              done;
  logic [1:0]        status;

  modport master (
    output start, stall,
    input  a_addr, b_addr, rd_en, acc_en, acc_first, c_addr, c_we, busy, done, status
  );

  modport slave (
    input  start, stall,
    output a_addr, b_addr, rd_en, acc_en, acc_first, c_addr, c_we, busy, done, status
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Walks every C[i][j] of an NxN product: issues A/B reads for k=0..N-1,
// steers the accumulator one cycle behind the reads, then writes the element.
module matmul_sequencer #(
  parameter int N      = 4,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  matmul_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic              rd_en_q, rd_en_d, rd_first_q, rd_first_d;
  logic              acc_en_q, acc_en_d, acc_first_q, acc_first_d;
  logic              c_we_q, c_we_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]        status_q, status_d;

  function automatic logic [ADDR_W-1:0] idx(input logic [IDX_W-1:0] row,
                                            input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      c_addr_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_first_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      c_we_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      c_addr_q    <= c_addr_d;
      rd_en_q     <= rd_en_d;
      rd_first_q  <= rd_first_d;
      acc_en_q    <= acc_en_d;
      acc_first_q <= acc_first_d;
      c_we_q      <= c_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  // Outputs are registered from the current state, so each strobe appears one
  // cycle after the state that decided it; c_we thus lands after the last acc_en.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    c_addr_d    = c_addr_q;
    rd_en_d     = 1'b0;
    rd_first_d  = 1'b0;
    acc_en_d    = rd_en_q;
    acc_first_d = rd_first_q;
    c_we_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          rd_en_d    = 1'b1;
          rd_first_d = (k_q == '0);
          a_addr_d   = idx(i_q, k_q);
          b_addr_d   = idx(k_q, j_q);
          if (k_q == LAST) state_d = S_DRAIN;
          else             k_d     = k_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        c_we_d   = 1'b1;
        c_addr_d = idx(i_q, j_q);
        k_d      = '0;
        if (j_q != LAST) begin
          j_d     = j_q + 1'b1;
          state_d = S_RUN;
        end else if (i_q != LAST) begin
          j_d     = '0;
          i_d     = i_q + 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
    case (state_d)
      S_IDLE:  status_d = 2'b00;
      S_DONE:  status_d = 2'b11;
      default: status_d = 2'b01;
    endcase
  end

  assign bus.a_addr    = a_addr_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.acc_first = acc_first_q;
  assign bus.c_addr    = c_addr_q;
  assign bus.c_we      = c_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: stall-pattern table over full N=4 runs with an address
// scoreboard, plus start-hold, mid-run reset and N=1 sequences.
module tb_matmul_sequencer;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n;

  matmul_sequencer_if #(.ADDR_W(8)) ifc4 ();
  matmul_sequencer_if #(.ADDR_W(2)) ifc1 ();

  matmul_sequencer #(.N(4), .IDX_W(4), .ADDR_W(8)) dut4 (
    .clock(clock), .reset_n(reset_n), .bus(ifc4)
  );
  matmul_sequencer #(.N(1), .IDX_W(1), .ADDR_W(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(ifc1)
  );

  always #5 clock = ~clock;

  int vec_count  = 0;
  int miss_count = 0;

  int qa[$];
  int qb[$];
  int qc[$];
  int rd_seen, c_seen;
  bit prev_rd, prev_k0, cur_k0;

  typedef struct {
    int stall_at;
    int stall_len;
    int hold_a;
    int exp_cycles;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miss_count++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic push_expect();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          qa.push_back(i * N + k);
          qb.push_back(k * N + j);
        end
        qc.push_back(i * N + j);
      end
  endtask

  // Scoreboard monitor on the N=4 instance, sampling on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_rd = 1'b0;
      prev_k0 = 1'b0;
    end else begin
      if (prev_rd || ifc4.acc_en) begin
        chk("acc_en", int'(ifc4.acc_en), int'(prev_rd));
        chk("acc_first", int'(ifc4.acc_first), int'(prev_rd && prev_k0));
      end
      cur_k0 = 1'b0;
      if (ifc4.rd_en) begin
        rd_seen++;
        if (qa.size() == 0) begin
          vec_count++;
          miss_count++;
          $display("FAIL rd_unexpected: got a_addr %0d, expected no read", ifc4.a_addr);
        end else begin
          int ea, eb;
          ea = qa.pop_front();
          eb = qb.pop_front();
          chk("a_addr", int'(ifc4.a_addr), ea);
          chk("b_addr", int'(ifc4.b_addr), eb);
          cur_k0 = (ea % N == 0);
        end
      end
      prev_rd = ifc4.rd_en;
      prev_k0 = cur_k0;
      if (ifc4.c_we) begin
        c_seen++;
        if (qc.size() == 0) begin
          vec_count++;
          miss_count++;
          $display("FAIL c_we_unexpected: got c_addr %0d, expected no write", ifc4.c_addr);
        end else begin
          chk("c_addr", int'(ifc4.c_addr), qc.pop_front());
        end
      end
    end
  end

  task automatic run_matrix(input int stall_at, input int stall_len, input int hold_a,
                            input int abort_at, input bit hold, output int cycles);
    cycles  = -1;
    rd_seen = 0;
    c_seen  = 0;
    push_expect();
    ifc4.start = 1'b1;
    step();
    if (!hold) ifc4.start = 1'b0;
    chk("run_status", int'(ifc4.status), 1);
    chk("run_busy", int'(ifc4.busy), 1);
    for (int c = 0; c < 400; c++) begin
      if (ifc4.done) begin
        cycles = c;
        break;
      end
      if (c > stall_at && c <= stall_at + stall_len) begin
        chk("stall_rd_en", int'(ifc4.rd_en), 0);
        chk("stall_a_hold", int'(ifc4.a_addr), hold_a);
      end
      if (c == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_rd_en", int'(ifc4.rd_en), 0);
        chk("rst_acc", int'({ifc4.acc_en, ifc4.acc_first}), 0);
        chk("rst_c_we", int'(ifc4.c_we), 0);
        chk("rst_addrs", int'(ifc4.a_addr) + int'(ifc4.b_addr) + int'(ifc4.c_addr), 0);
        chk("rst_busy_done", int'({ifc4.busy, ifc4.done}), 0);
        chk("rst_status", int'(ifc4.status), 0);
        ifc4.start = 1'b0;
        ifc4.stall = 1'b0;
        step();
        reset_n = 1'b1;
        qa.delete();
        qb.delete();
        qc.delete();
        cycles = -2;
        break;
      end
      ifc4.stall = (c >= stall_at && c < stall_at + stall_len);
      step();
    end
    ifc4.stall = 1'b0;
    if (cycles == -1) begin
      vec_count++;
      miss_count++;
      $display("FAIL run_timeout: got no done within 400 cycles, expected done");
    end
  endtask

  task automatic check_complete(input int cycles, input int exp_cycles);
    chk("run_cycles", cycles, exp_cycles);
    chk("rd_count", rd_seen, N * N * N);
    chk("c_we_count", c_seen, N * N);
    chk("reads_left", qa.size(), 0);
    chk("writes_left", qc.size(), 0);
    chk("done_status", int'(ifc4.status), 3);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{stall_at: 0,  stall_len: 0, hold_a: 0, exp_cycles: 96};
    tbl[1] = '{stall_at: 3,  stall_len: 3, hold_a: 2, exp_cycles: 99};
    tbl[2] = '{stall_at: 13, stall_len: 1, hold_a: 0, exp_cycles: 97};
    tbl[3] = '{stall_at: 4,  stall_len: 2, hold_a: 3, exp_cycles: 96};
    tbl[4] = '{stall_at: 3,  stall_len: 5, hold_a: 2, exp_cycles: 101};

    reset_n    = 1'b0;
    ifc4.start = 1'b0;
    ifc4.stall = 1'b0;
    ifc1.start = 1'b0;
    ifc1.stall = 1'b0;
    step();
    step();
    chk("reset_status", int'(ifc4.status), 0);
    chk("reset_strobes", int'({ifc4.rd_en, ifc4.acc_en, ifc4.c_we, ifc4.busy, ifc4.done}), 0);
    chk("reset_addrs", int'(ifc4.a_addr) + int'(ifc4.b_addr) + int'(ifc4.c_addr), 0);
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) step();
    chk("idle_status", int'(ifc4.status), 0);
    chk("idle_busy", int'(ifc4.busy), 0);

    foreach (tbl[v]) begin
      run_matrix(tbl[v].stall_at, tbl[v].stall_len, tbl[v].hold_a, -1, 1'b0, cyc);
      check_complete(cyc, tbl[v].exp_cycles);
      step();
      chk("done_pulse_len", int'(ifc4.done), 0);
      chk("done_hold_status", int'(ifc4.status), 3);
      chk("done_busy", int'(ifc4.busy), 0);
    end

    // start held high for a whole run, then the held start restarts from DONE
    run_matrix(0, 0, 0, -1, 1'b1, cyc);
    check_complete(cyc, 96);
    // restart run aborted by reset while on element (2,3)
    run_matrix(0, 0, 0, 67, 1'b0, cyc);
    chk("abort_seen", cyc, -2);
    step();
    chk("post_abort_status", int'(ifc4.status), 0);
    run_matrix(0, 0, 0, -1, 1'b0, cyc);
    check_complete(cyc, 96);

    // N=1 build
    ifc1.start = 1'b1;
    step();
    ifc1.start = 1'b0;
    chk("n1_status_run", int'(ifc1.status), 1);
    chk("n1_rd_early", int'(ifc1.rd_en), 0);
    step();
    chk("n1_rd_en", int'(ifc1.rd_en), 1);
    chk("n1_addrs", int'(ifc1.a_addr) + int'(ifc1.b_addr), 0);
    step();
    chk("n1_acc", int'({ifc1.acc_en, ifc1.acc_first}), 3);
    chk("n1_rd_off", int'(ifc1.rd_en), 0);
    step();
    chk("n1_c_we", int'(ifc1.c_we), 1);
    chk("n1_c_addr", int'(ifc1.c_addr), 0);
    chk("n1_done", int'(ifc1.done), 1);
    chk("n1_status_done", int'(ifc1.status), 3);
    step();
    chk("n1_done_pulse", int'({ifc1.done, ifc1.c_we}), 0);
    chk("n1_status_hold", int'(ifc1.status), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Sequencing controller for the N×N matrix-multiplication MAC datapath.
- On a start request it walks every output element C[i][j]: issues A/B operand addresses for k = 0..N-1, steers the accumulator load/add controls, and writes the finished element back.
- Reports prepare/process/complete status in the same 2-bit encoding the top-level state controller uses (00/01/11).

Parameters:
- N, 4, matrix dimension; legal range 1..16.
- IDX_W, 4, index counter width; must satisfy 2^IDX_W >= N.
- ADDR_W, 8, operand/result address width, equal to 2*IDX_W; addresses are row-major (row*N + col).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- stall  input  1  operand memory not ready; freezes address issue in RUN.
- a_addr  output  ADDR_W  A operand read address, i*N+k.
- b_addr  output  ADDR_W  B operand read address, k*N+j.
- rd_en  output  1  operand read strobe; high on each cycle an address pair is issued.
- acc_en  output  1  accumulator update; product data valid this cycle.
- acc_first  output  1  with acc_en: load the product instead of adding it (k==0 term).
- c_addr  output  ADDR_W  result write address, i*N+j.
- c_we  output  1  result write strobe, one cycle per element.
- busy  output  1  high in RUN, DRAIN and WRITE.
- done  output  1  single-cycle pulse on entry to DONE.
- status  output  2  00 prepare (IDLE), 01 process (RUN/DRAIN/WRITE), 11 complete (DONE).

Behaviour:
- Reset (async, reset_n=0): state IDLE; i, j and k = 0; all strobes 0; all addresses 0; status 00; the pipeline valid flag is cleared.
- Reset asserted mid-run aborts immediately. No write completes after reset asserts.
- States: IDLE, RUN, DRAIN, WRITE, DONE. All outputs are registered.
- IDLE: when start=1, clear i, j and k, then go to RUN. Otherwise stay.
- RUN, stall=0:
  - Assert rd_en with a_addr=i*N+k and b_addr=k*N+j.
  - If k==N-1, go to DRAIN. Otherwise k++.
- RUN, stall=1: rd_en=0; addresses hold; k holds.
- Operand read latency is fixed at 1 cycle.
  - acc_en is rd_en delayed by one cycle.
  - acc_first is (rd_en && k==0) delayed by one cycle.
- DRAIN: one cycle, so the final product accumulates. Then go to WRITE.
- WRITE: c_we=1 for exactly one cycle, with c_addr=i*N+j.
  - If j<N-1: j++, k=0, go to RUN.
  - Else if i<N-1: j=0, i++, k=0, go to RUN.
  - Else go to DONE.
- stall affects only address issue in RUN. An in-flight product still produces acc_en. DRAIN and WRITE ignore stall.
- DONE: done=1 on the first DONE cycle only. status stays 11 until start=1, which restarts exactly as from IDLE.
- start seen in RUN, DRAIN or WRITE is ignored and not queued.
- Latency with no stalls: N+2 cycles per element; N*N*(N+2) cycles from the first RUN cycle to DONE entry (96 for N=4).
- N=1: RUN lasts one issue cycle, and acc_first is set on the only product.

Test Plan:
- N=4, reset then start one cycle, no stall:
  - rd_en pulses 64 times.
  - c_we pulses 16 times with c_addr 0,1,...,15 in order.
  - done pulses on cycle 96 after entering RUN; status reads 00→01→11.
- Element (1,2) address check: a_addr 4,5,6,7 paired with b_addr 2,6,10,14; acc_first is high only on the acc_en cycle after a_addr=4; then c_addr=6.
- stall=1 for 3 cycles while k==2 in element (0,0):
  - a_addr holds at 2 and rd_en is low for those cycles.
  - Total rd_en count is unchanged at 64; run length grows by exactly 3 cycles.
- start held high throughout a run: no restart mid-run. When start is still high in DONE, a new run begins with a_addr=0 and status returns to 01.
- reset_n pulsed low in RUN while on element (2,3): all outputs are 0 and status is 00 immediately (asynchronous). A subsequent start restarts at element (0,0).
- N=1 build: start → rd_en and acc_en+acc_first → c_we at c_addr=0 → done. This is 3 cycles from RUN entry to DONE.
